lock_controller: RTL
====================

LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 SHALL have parameter DEFAULT_CODE, default 32'h1234_5678, meaning the code loaded into the data saver after reset (digit1 in [3:0]).
REQ-002 SHALL have parameter OPEN_CYCLES, default 16, meaning the number of cycles unlocked is held.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 64, meaning the duration of alarm lockout.
REQ-004 SHALL have parameter MAX_FAILS, default 3, range 1..7, meaning consecutive failed checks before lockout.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port key_valid, input, 1 bit: a one-cycle digit strobe.
REQ-008 SHALL have port key_code, input, 4 bits: digit value, qualified by key_valid.
REQ-009 SHALL have port key_enter, input, 1 bit: submit pulse.
REQ-010 SHALL have port key_clear, input, 1 bit: clear pulse.
REQ-011 SHALL have port key_set, input, 1 bit: request to enter program mode.
REQ-012 SHALL have port stored_code, input, 32 bits: the data saver outputs digit1..digit8, with digit1 in [3:0].
REQ-013 SHALL have port state, output, 3 bits: FSM state, driving the data saver state input.
REQ-014 SHALL have port state_save, output, 3 bits: constant 3'd5, driving the data saver state_save input.
REQ-015 SHALL have port insert_data, output, 32 bits: entry buffer, driving digit1..digit8 insertdata.
REQ-016 SHALL have port digit_count, output, 4 bits: digits entered, 0..8.
REQ-017 SHALL have port unlocked, output, 1 bit: high in OPEN.
REQ-018 SHALL have port alarm, output, 1 bit: high in LOCKOUT.

Function
REQ-019 SHALL use the state encoding IDLE=0, ENTER=1, CHECK=2, OPEN=3, PROG=4, SAVE=5, ERROR=6, LOCKOUT=7, registered and driven directly on state.
REQ-020 SHALL ignore a key_valid whose key_code is greater than 9, with no state change.
REQ-021 SHALL store an accepted digit at position digit_count+1 (first digit into [3:0]) and increment digit_count, in IDLE, ENTER or PROG; a 9th or later digit is ignored.
REQ-022 SHALL move IDLE->ENTER on the first accepted digit.
REQ-023 SHALL apply same-cycle priority key_clear > key_enter > key_valid; lower-priority inputs are dropped.
REQ-024 SHALL handle key_clear as follows: ENTER->IDLE, PROG stays in PROG; in both cases buffer and digit_count are zeroed.
REQ-025 SHALL handle key_enter in ENTER as follows: digit_count==8 -> CHECK; digit_count<8 -> fail_cnt+1, then ERROR, or LOCKOUT if fail_cnt reaches MAX_FAILS; key_enter in IDLE is ignored.
REQ-026 SHALL stay in CHECK for one cycle, comparing insert_data==stored_code; on match -> OPEN with fail_cnt=0; on mismatch -> fail_cnt+1, then LOCKOUT if it reaches MAX_FAILS, else ERROR.
REQ-027 SHALL stay in ERROR for one cycle, then go to IDLE with buffer and digit_count zeroed.
REQ-028 SHALL hold OPEN for exactly OPEN_CYCLES cycles, then go to IDLE; key_set in OPEN -> PROG with buffer zeroed; digits are ignored in OPEN.
REQ-029 SHALL handle key_enter in PROG as follows: digit_count==8 -> SAVE; <8 -> ERROR, with fail_cnt unchanged.
REQ-030 SHALL stay in SAVE for exactly one cycle with insert_data stable, then go to IDLE with buffer zeroed.
REQ-031 SHALL hold LOCKOUT for exactly LOCKOUT_CYCLES cycles, ignoring all key inputs, then go to IDLE with fail_cnt=0.
REQ-032 SHALL use a single down-counter for the OPEN and LOCKOUT timers, loaded on state entry; it SHALL NOT wrap.
REQ-033 SHALL drive unlocked=1 iff state==OPEN and alarm=1 iff state==LOCKOUT, both registered-state decodes.
REQ-034 SHALL saturate fail_cnt at MAX_FAILS.

Reset
REQ-035 SHALL, while rst=1, asynchronously force state=SAVE, insert_data=DEFAULT_CODE, digit_count=0, fail_cnt=0, timer=0, unlocked=0, alarm=0.
REQ-036 SHALL, on the first clk edge after rst deasserts, go SAVE->IDLE, so the data saver captures DEFAULT_CODE; the buffer is then zeroed.
REQ-037 SHALL abort any operation on rst assertion mid-operation, including OPEN, PROG and LOCKOUT, with no partial save.

Verification
REQ-038 SHALL cover: reset, then enter 1,2,3,4,5,6,7,8 and key_enter -> CHECK for 1 cycle, then OPEN with unlocked=1 for 16 cycles, then IDLE.
REQ-039 SHALL cover: three wrong 8-digit codes -> ERROR, ERROR, then LOCKOUT with alarm=1 for 64 cycles; keys are ignored; then IDLE with fail_cnt=0.
REQ-040 SHALL cover: open, key_set, enter 9,9,9,9,0,0,0,0 and key_enter -> SAVE for 1 cycle with insert_data=32'h0000_9999; the old code then fails and the new code opens.
REQ-041 SHALL cover: key_clear+key_enter+key_valid in the same cycle in ENTER -> IDLE with digit_count=0; key_code=4'hA is ignored.
REQ-042 SHALL cover: 5 digits then key_enter -> ERROR with fail_cnt=1; 10 digits -> digit_count stays 8 and the buffer holds the first 8.
REQ-043 SHALL cover: rst asserted mid-PROG after 4 digits -> immediate state=5 with insert_data=DEFAULT_CODE; the stored code then equals DEFAULT_CODE.

Source files
------------

// File: rtl/lock_controller.sv
// Keypad lock controller: collects 8 BCD digits, checks them against the code held
// by an external data saver, and runs the open / program / lockout sequencing.
module lock_controller #(
    parameter logic [31:0] DEFAULT_CODE   = 32'h1234_5678,
    parameter int          OPEN_CYCLES    = 16,
    parameter int          LOCKOUT_CYCLES = 64,
    parameter int          MAX_FAILS      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        key_set,
    input  logic [31:0] stored_code,
    output logic [2:0]  state,
    output logic [2:0]  state_save,
    output logic [31:0] insert_data,
    output logic [3:0]  digit_count,
    output logic        unlocked,
    output logic        alarm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        PROG    = 3'd4,
        SAVE    = 3'd5,
        ERROR   = 3'd6,
        LOCKOUT = 3'd7
    } state_t;

    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [2:0] FAIL_LIM = 3'(MAX_FAILS);

    state_t        cur, nxt;
    logic [31:0]   buf_n;
    logic [3:0]    cnt_n;
    logic [2:0]    fail_cnt, fail_n, fail_inc;
    logic [TW-1:0] timer, timer_n;
    logic          digit_ok;

    assign state      = cur;
    assign state_save = 3'd5;
    assign unlocked   = (cur == OPEN);
    assign alarm      = (cur == LOCKOUT);

    assign digit_ok = key_valid && (key_code <= 4'd9) && (digit_count < 4'd8);
    assign fail_inc = (fail_cnt >= FAIL_LIM) ? FAIL_LIM : fail_cnt + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= SAVE;
            insert_data <= DEFAULT_CODE;
            digit_count <= '0;
            fail_cnt    <= '0;
            timer       <= '0;
        end else begin
            cur         <= nxt;
            insert_data <= buf_n;
            digit_count <= cnt_n;
            fail_cnt    <= fail_n;
            timer       <= timer_n;
        end
    end

    always_comb begin
        nxt     = cur;
        buf_n   = insert_data;
        cnt_n   = digit_count;
        fail_n  = fail_cnt;
        timer_n = (timer != '0) ? timer - TW'(1) : '0;

        case (cur)
            IDLE, ENTER, PROG: begin
                if (key_clear) begin
                    nxt   = (cur == PROG) ? PROG : IDLE;
                    buf_n = '0;
                    cnt_n = '0;
                end else if (key_enter) begin
                    if (cur == PROG) begin
                        nxt = (digit_count == 4'd8) ? SAVE : ERROR;
                    end else if (cur == ENTER) begin
                        if (digit_count == 4'd8) begin
                            nxt = CHECK;
                        end else begin
                            fail_n = fail_inc;
                            nxt    = (fail_inc >= FAIL_LIM) ? LOCKOUT : ERROR;
                        end
                    end
                end else if (digit_ok) begin
                    buf_n[{digit_count[2:0], 2'b00} +: 4] = key_code;
                    cnt_n = digit_count + 4'd1;
                    if (cur == IDLE) nxt = ENTER;
                end
            end
            CHECK: begin
                if (insert_data == stored_code) begin
                    nxt    = OPEN;
                    fail_n = '0;
                end else begin
                    fail_n = fail_inc;
                    nxt    = (fail_inc >= FAIL_LIM) ? LOCKOUT : ERROR;
                end
            end
            OPEN: begin
                if (key_set)           nxt = PROG;
                else if (timer == '0)  nxt = IDLE;
            end
            SAVE, ERROR: nxt = IDLE;
            LOCKOUT: begin
                if (timer == '0) begin
                    nxt    = IDLE;
                    fail_n = '0;
                end
            end
            default: nxt = IDLE;
        endcase

        // Timer counts the remaining cycles after the current one, so load N-1 on entry.
        if (nxt != cur && nxt == OPEN)    timer_n = TW'(OPEN_CYCLES - 1);
        if (nxt != cur && nxt == LOCKOUT) timer_n = TW'(LOCKOUT_CYCLES - 1);

        // Any state that is not collecting or consuming digits starts from an empty buffer.
        if (nxt == IDLE || nxt == OPEN || nxt == ERROR || nxt == LOCKOUT ||
            (nxt == PROG && cur == OPEN)) begin
            buf_n = '0;
            cnt_n = '0;
        end
    end

endmodule
